// File: rtl/mem_stage_ctrl.sv
// Type definitions shared by the pipeline latches around the memory stage.
// EX|MEM carries the decoded controls plus operands; MEM|WB carries the
// writeback payload selected here.
package aww_types_pkg;

    typedef struct packed {
        logic [31:0] pc_plus;
        logic [31:0] aluout;
        logic [31:0] rdat2;
        logic [15:0] imm;
        logic [4:0]  wsel;
        logic        RegWr;
        logic        DataRead;
        logic        DataWrite;
        logic        Jal;
        logic        ImmToReg;
        logic        LoadLinked;
        logic        StoreConditional;
        logic        Halt;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wdat;
        logic [31:0] dmemload;
        logic [31:0] pc_plus;
        logic [4:0]  wsel;
        logic        RegWr;
        logic        DataRead;
        logic        Halt;
    } memwb_t;

endpackage

// Memory stage controller: issues dcache requests, tracks LL/SC link, builds MEM|WB.
// Latency: non-memory ops 1 cycle; memory ops 1 + cycles until dhit.
// Backpressure: mem_stall holds upstream while a memory op waits for dhit.
module mem_stage_ctrl
    import aww_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  exmem_t      exmem,
    input  logic        exmem_valid,
    input  logic        dhit,
    input  logic [31:0] dload,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output memwb_t      memwb,
    output logic        memwb_valid,
    output logic        mem_stall,
    output logic        halt
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    state_t      nextState;

    // Request fields frozen for the duration of an access.
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        reqRead;
    logic        reqWrite;

    logic [31:0] linkAddr;
    logic        linkValid;
    logic [31:0] linkAddrNext;

    logic        linkHit;
    logic        scFail;
    logic        issueReq;
    logic        accessDone;
    logic        llSet;
    logic        scDone;
    logic        snoopHit;
    logic        loadMemwb;
    memwb_t      memwbNext;

    // A failing SC never touches memory, so it is not a qualifying request.
    // Gating with nRST keeps mem_stall low while reset is held.
    assign linkHit    = linkValid && (linkAddr == exmem.aluout);
    assign scFail     = exmem.StoreConditional && !linkHit;
    assign issueReq   = nRST && exmem_valid && (exmem.DataRead || exmem.DataWrite)
                        && !halt && !scFail;
    assign accessDone = (state == ACCESS) && dhit;

    assign daddr  = (state == ACCESS) ? reqAddr : exmem.aluout;
    assign dstore = (state == ACCESS) ? reqData : exmem.rdat2;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus request/stall outputs.
    always_comb begin
        nextState = state;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (issueReq) begin
                    nextState = ACCESS;
                    mem_stall = 1'b1;
                end
            end
            ACCESS: begin
                dREN = reqRead;
                dWEN = reqWrite && !reqRead;
                if (dhit) begin
                    nextState = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Capture the request on IDLE->ACCESS so a wobbling exmem cannot disturb it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            reqAddr  <= '0;
            reqData  <= '0;
            reqRead  <= 1'b0;
            reqWrite <= 1'b0;
        end else if ((state == IDLE) && issueReq) begin
            reqAddr  <= exmem.aluout;
            reqData  <= exmem.rdat2;
            reqRead  <= exmem.DataRead;
            reqWrite <= exmem.DataWrite;
        end
    end

    // Link bookkeeping: LL sets at its dhit, any SC completion or matching snoop clears.
    // The snoop compares against the address being written this edge, so a snoop
    // coinciding with an LL to the same word wins over the set.
    always_comb begin
        llSet        = accessDone && exmem.LoadLinked;
        scDone       = exmem.StoreConditional &&
                       (accessDone ||
                        ((state == IDLE) && exmem_valid && !halt && scFail));
        linkAddrNext = llSet ? reqAddr : linkAddr;
        snoopHit     = snoop_inv && (snoop_addr == linkAddrNext);
    end

    // Link register update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            linkAddr  <= '0;
            linkValid <= 1'b0;
        end else begin
            linkAddr <= linkAddrNext;
            if (snoopHit || scDone) begin
                linkValid <= 1'b0;
            end else if (llSet) begin
                linkValid <= 1'b1;
            end
        end
    end

    // MEM|WB payload and the condition under which it is loaded.
    // An SC that reached ACCESS was a success; in IDLE the only SC seen is a failure.
    always_comb begin
        memwbNext          = '0;
        memwbNext.pc_plus  = exmem.pc_plus;
        memwbNext.wsel     = exmem.wsel;
        memwbNext.RegWr    = exmem.RegWr;
        memwbNext.DataRead = exmem.DataRead;
        memwbNext.Halt     = exmem.Halt;
        memwbNext.dmemload = accessDone ? dload : 32'h0;
        if (exmem.Jal) begin
            memwbNext.wdat = exmem.pc_plus;
        end else if (exmem.StoreConditional) begin
            memwbNext.wdat = {31'b0, (state == ACCESS)};
        end else if (exmem.ImmToReg) begin
            memwbNext.wdat = {exmem.imm, 16'h0000};
        end else begin
            memwbNext.wdat = exmem.aluout;
        end
        if (state == ACCESS) begin
            loadMemwb = dhit;
        end else begin
            loadMemwb = exmem_valid && !halt && !issueReq;
        end
    end

    // MEM|WB latch and sticky halt.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            memwb       <= '0;
            memwb_valid <= 1'b0;
            halt        <= 1'b0;
        end else begin
            memwb_valid <= loadMemwb;
            if (loadMemwb) begin
                memwb <= memwbNext;
                if (exmem.Halt) begin
                    halt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import aww_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    exmem_t      exmem;
    logic        exmem_valid;
    logic        dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    memwb_t      memwb;
    logic        memwb_valid;
    logic        mem_stall;
    logic        halt;

    int testsRun    = 0;
    int testsFailed = 0;

    exmem_t opLw, opLl, opSc, opSw, opJal, opLui, opHalt, opTmp;

    mem_stage_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .exmem       (exmem),
        .exmem_valid (exmem_valid),
        .dhit        (dhit),
        .dload       (dload),
        .snoop_inv   (snoop_inv),
        .snoop_addr  (snoop_addr),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .memwb       (memwb),
        .memwb_valid (memwb_valid),
        .mem_stall   (mem_stall),
        .halt        (halt)
    );

    always #5 CLK = ~CLK;

    // Present an op at posedge+1 and return at the following negedge.
    task automatic driveOp(input exmem_t o);
        exmem       = o;
        exmem_valid = 1'b1;
        dhit        = 1'b0;
        dload       = 32'h0;
        @(negedge CLK);
    endtask

    task automatic nextCycle(input logic hit, input logic [31:0] data);
        @(posedge CLK);
        #1;
        dhit  = hit;
        dload = hit ? data : 32'h0;
        @(negedge CLK);
    endtask

    task automatic endOp();
        @(posedge CLK);
        #1;
        exmem_valid = 1'b0;
        dhit        = 1'b0;
        dload       = 32'h0;
    endtask

    task automatic runAccess(input exmem_t o, input int hitCycle);
        driveOp(o);
        for (int c = 1; c <= hitCycle; c++) nextCycle(c == hitCycle, 32'h0);
        endOp();
    endtask

    task automatic test_reset();
        nRST        = 1'b0;
        exmem       = opLw;
        exmem_valid = 1'b1;
        dhit        = 1'b0;
        dload       = 32'h0;
        snoop_inv   = 1'b0;
        snoop_addr  = 32'h0;
        #2;
        testsRun++;
        if (memwb !== '0) begin testsFailed++; $display("FAIL reset_memwb: got %h want 0", memwb); end
        testsRun++;
        if (memwb_valid !== 1'b0) begin testsFailed++; $display("FAIL reset_memwb_valid: got %b want 0", memwb_valid); end
        testsRun++;
        if (halt !== 1'b0) begin testsFailed++; $display("FAIL reset_halt: got %b want 0", halt); end
        testsRun++;
        if (dREN !== 1'b0 || dWEN !== 1'b0) begin testsFailed++; $display("FAIL reset_req: got dREN=%b dWEN=%b want 0 0", dREN, dWEN); end
        testsRun++;
        if (mem_stall !== 1'b0) begin testsFailed++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
        exmem_valid = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_lw();
        int renCnt;
        int stallCnt;
        renCnt   = 0;
        stallCnt = 0;
        driveOp(opLw);
        if (dREN === 1'b1) renCnt++;
        if (mem_stall === 1'b1) stallCnt++;
        for (int c = 1; c <= 3; c++) begin
            nextCycle(c == 3, 32'hDEAD_BEEF);
            if (dREN === 1'b1) renCnt++;
            if (mem_stall === 1'b1) stallCnt++;
            if (c == 1) begin
                testsRun++;
                if (daddr !== 32'h40) begin testsFailed++; $display("FAIL lw_daddr: got %h want 00000040", daddr); end
            end
        end
        endOp();
        testsRun++;
        if (renCnt != 3) begin testsFailed++; $display("FAIL lw_dren_cycles: got %0d want 3", renCnt); end
        testsRun++;
        if (stallCnt != 3) begin testsFailed++; $display("FAIL lw_stall_cycles: got %0d want 3", stallCnt); end
        testsRun++;
        if (memwb_valid !== 1'b1) begin testsFailed++; $display("FAIL lw_memwb_valid: got %b want 1", memwb_valid); end
        testsRun++;
        if (memwb.dmemload !== 32'hDEAD_BEEF) begin testsFailed++; $display("FAIL lw_dmemload: got %h want deadbeef", memwb.dmemload); end
        testsRun++;
        if (memwb.wdat !== 32'h40) begin testsFailed++; $display("FAIL lw_wdat: got %h want 00000040", memwb.wdat); end
        @(negedge CLK);
        testsRun++;
        if (dREN !== 1'b0) begin testsFailed++; $display("FAIL lw_dren_after: got %b want 0", dREN); end
    endtask

    task automatic test_ll_sc();
        runAccess(opLl, 1);
        driveOp(opSc);
        testsRun++;
        if (mem_stall !== 1'b1) begin testsFailed++; $display("FAIL sc_issue_stall: got %b want 1", mem_stall); end
        nextCycle(1'b1, 32'h0);
        testsRun++;
        if (dWEN !== 1'b1 || dREN !== 1'b0) begin testsFailed++; $display("FAIL sc_req: got dWEN=%b dREN=%b want 1 0", dWEN, dREN); end
        testsRun++;
        if (dstore !== 32'h1234 || daddr !== 32'h80) begin testsFailed++; $display("FAIL sc_bus: got dstore=%h daddr=%h want 00001234 00000080", dstore, daddr); end
        endOp();
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h1) begin testsFailed++; $display("FAIL sc_result: got valid=%b wdat=%h want 1 00000001", memwb_valid, memwb.wdat); end
        // Link was consumed: a second SC to the same word must fail without a write.
        driveOp(opSc);
        testsRun++;
        if (mem_stall !== 1'b0 || dWEN !== 1'b0) begin testsFailed++; $display("FAIL sc_again_req: got stall=%b dWEN=%b want 0 0", mem_stall, dWEN); end
        endOp();
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h0) begin testsFailed++; $display("FAIL sc_again_result: got valid=%b wdat=%h want 1 00000000", memwb_valid, memwb.wdat); end
    endtask

    task automatic test_snoop();
        // Matching snoop kills the link.
        runAccess(opLl, 1);
        snoop_inv  = 1'b1;
        snoop_addr = 32'h80;
        @(posedge CLK);
        #1;
        snoop_inv = 1'b0;
        driveOp(opSc);
        testsRun++;
        if (mem_stall !== 1'b0 || dWEN !== 1'b0) begin testsFailed++; $display("FAIL snoop_sc_req: got stall=%b dWEN=%b want 0 0", mem_stall, dWEN); end
        endOp();
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h0) begin testsFailed++; $display("FAIL snoop_sc_result: got valid=%b wdat=%h want 1 00000000", memwb_valid, memwb.wdat); end
        // Snoop to another word leaves the link intact.
        runAccess(opLl, 1);
        snoop_inv  = 1'b1;
        snoop_addr = 32'h84;
        @(posedge CLK);
        #1;
        snoop_inv = 1'b0;
        driveOp(opSc);
        testsRun++;
        if (mem_stall !== 1'b1) begin testsFailed++; $display("FAIL snoop_other_stall: got %b want 1", mem_stall); end
        nextCycle(1'b1, 32'h0);
        testsRun++;
        if (dWEN !== 1'b1) begin testsFailed++; $display("FAIL snoop_other_dwen: got %b want 1", dWEN); end
        endOp();
        testsRun++;
        if (memwb.wdat !== 32'h1) begin testsFailed++; $display("FAIL snoop_other_result: got %h want 00000001", memwb.wdat); end
        // Snoop on the same edge as the LL set: clear wins.
        driveOp(opLl);
        nextCycle(1'b1, 32'h0);
        snoop_inv  = 1'b1;
        snoop_addr = 32'h80;
        endOp();
        snoop_inv = 1'b0;
        driveOp(opSc);
        testsRun++;
        if (mem_stall !== 1'b0 || dWEN !== 1'b0) begin testsFailed++; $display("FAIL snoop_same_edge: got stall=%b dWEN=%b want 0 0", mem_stall, dWEN); end
        endOp();
    endtask

    task automatic test_jal_lui();
        driveOp(opJal);
        testsRun++;
        if (mem_stall !== 1'b0) begin testsFailed++; $display("FAIL jal_stall: got %b want 0", mem_stall); end
        @(posedge CLK);
        #1;
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h104) begin testsFailed++; $display("FAIL jal_wdat: got valid=%b wdat=%h want 1 00000104", memwb_valid, memwb.wdat); end
        driveOp(opLui);
        testsRun++;
        if (mem_stall !== 1'b0) begin testsFailed++; $display("FAIL lui_stall: got %b want 0", mem_stall); end
        endOp();
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h1234_0000) begin testsFailed++; $display("FAIL lui_wdat: got valid=%b wdat=%h want 1 12340000", memwb_valid, memwb.wdat); end
        // Bubble: valid drops, payload holds.
        opTmp         = opJal;
        opTmp.pc_plus = 32'h999;
        exmem         = opTmp;
        exmem_valid   = 1'b0;
        @(posedge CLK);
        #1;
        testsRun++;
        if (memwb_valid !== 1'b0 || memwb.wdat !== 32'h1234_0000) begin testsFailed++; $display("FAIL bubble_hold: got valid=%b wdat=%h want 0 12340000", memwb_valid, memwb.wdat); end
        // Jal outranks ImmToReg.
        opTmp          = opLui;
        opTmp.Jal      = 1'b1;
        opTmp.pc_plus  = 32'h200;
        runAccess(opTmp, 0);
        testsRun++;
        if (memwb.wdat !== 32'h200) begin testsFailed++; $display("FAIL prio_jal: got %h want 00000200", memwb.wdat); end
        // A failing SC outranks ImmToReg.
        opTmp                  = opSc;
        opTmp.ImmToReg         = 1'b1;
        opTmp.imm              = 16'h5555;
        runAccess(opTmp, 0);
        testsRun++;
        if (memwb.wdat !== 32'h0) begin testsFailed++; $display("FAIL prio_sc: got %h want 00000000", memwb.wdat); end
    endtask

    task automatic test_reset_mid();
        driveOp(opSw);
        nextCycle(1'b0, 32'h0);
        testsRun++;
        if (dWEN !== 1'b1) begin testsFailed++; $display("FAIL rst_mid_dwen_before: got %b want 1", dWEN); end
        #1;
        nRST = 1'b0;
        #1;
        testsRun++;
        if (dWEN !== 1'b0 || mem_stall !== 1'b0) begin testsFailed++; $display("FAIL rst_mid_abort: got dWEN=%b stall=%b want 0 0", dWEN, mem_stall); end
        testsRun++;
        if (memwb_valid !== 1'b0 || memwb.wdat !== 32'h0) begin testsFailed++; $display("FAIL rst_mid_memwb: got valid=%b wdat=%h want 0 00000000", memwb_valid, memwb.wdat); end
        exmem_valid = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        testsRun++;
        if (dWEN !== 1'b0 || dREN !== 1'b0 || mem_stall !== 1'b0) begin testsFailed++; $display("FAIL rst_mid_release: got dWEN=%b dREN=%b stall=%b want 0 0 0", dWEN, dREN, mem_stall); end
        opTmp         = opJal;
        opTmp.pc_plus = 32'h300;
        driveOp(opTmp);
        testsRun++;
        if (mem_stall !== 1'b0) begin testsFailed++; $display("FAIL rst_mid_idle_stall: got %b want 0", mem_stall); end
        endOp();
        testsRun++;
        if (memwb_valid !== 1'b1 || memwb.wdat !== 32'h300) begin testsFailed++; $display("FAIL rst_mid_idle_pass: got valid=%b wdat=%h want 1 00000300", memwb_valid, memwb.wdat); end
    endtask

    task automatic test_halt();
        int renCnt;
        int stallCnt;
        renCnt   = 0;
        stallCnt = 0;
        driveOp(opHalt);
        testsRun++;
        if (halt !== 1'b0) begin testsFailed++; $display("FAIL halt_early: got %b want 0", halt); end
        endOp();
        testsRun++;
        if (halt !== 1'b1 || memwb_valid !== 1'b1 || memwb.Halt !== 1'b1) begin testsFailed++; $display("FAIL halt_set: got halt=%b valid=%b memwb.Halt=%b want 1 1 1", halt, memwb_valid, memwb.Halt); end
        driveOp(opLw);
        if (dREN === 1'b1) renCnt++;
        if (mem_stall === 1'b1) stallCnt++;
        for (int c = 0; c < 2; c++) begin
            nextCycle(1'b0, 32'h0);
            if (dREN === 1'b1) renCnt++;
            if (mem_stall === 1'b1) stallCnt++;
        end
        endOp();
        testsRun++;
        if (renCnt != 0 || stallCnt != 0) begin testsFailed++; $display("FAIL halt_lw_req: got dREN cycles=%0d stall cycles=%0d want 0 0", renCnt, stallCnt); end
        testsRun++;
        if (memwb_valid !== 1'b0 || halt !== 1'b1) begin testsFailed++; $display("FAIL halt_sticky: got valid=%b halt=%b want 0 1", memwb_valid, halt); end
        nRST = 1'b0;
        #1;
        testsRun++;
        if (halt !== 1'b0) begin testsFailed++; $display("FAIL halt_reset: got %b want 0", halt); end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        opLw          = '0;
        opLw.DataRead = 1'b1;
        opLw.RegWr    = 1'b1;
        opLw.aluout   = 32'h40;
        opLw.wsel     = 5'd3;

        opLl            = '0;
        opLl.DataRead   = 1'b1;
        opLl.LoadLinked = 1'b1;
        opLl.RegWr      = 1'b1;
        opLl.aluout     = 32'h80;

        opSc                  = '0;
        opSc.DataWrite        = 1'b1;
        opSc.StoreConditional = 1'b1;
        opSc.RegWr            = 1'b1;
        opSc.aluout           = 32'h80;
        opSc.rdat2            = 32'h1234;

        opSw           = '0;
        opSw.DataWrite = 1'b1;
        opSw.aluout    = 32'h100;
        opSw.rdat2     = 32'h55;

        opJal         = '0;
        opJal.Jal     = 1'b1;
        opJal.RegWr   = 1'b1;
        opJal.pc_plus = 32'h104;
        opJal.aluout  = 32'hAAAA_AAAA;

        opLui          = '0;
        opLui.ImmToReg = 1'b1;
        opLui.RegWr    = 1'b1;
        opLui.imm      = 16'h1234;
        opLui.aluout   = 32'h5555_5555;

        opHalt      = '0;
        opHalt.Halt = 1'b1;

        test_reset();
        test_lw();
        test_ll_sc();
        test_snoop();
        test_jal_lui();
        test_reset_mid();
        test_halt();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
